pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Collects stall requests from the IF, ID, EX and MEM stages and drives a per-stage stall vector to the PC register and to every inter-stage register (if_id, id_ex, ex_mem, mem_wb).
- Sequences multi-cycle exception flushes and supplies the redirect PC.
- Keeps a saturating stall-cycle performance counter and a stall watchdog.

Parameters:
- FLUSH_CYCLES, 1, cycles flush stays asserted after an exception is accepted (>=1).
- STALL_TIMEOUT, 1024, consecutive stalled cycles before stall_timeout sets (>=2).
- CNT_W, 32, width of stall_cnt.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- stallreq_if  in  1  IF requests hold (e.g. instruction memory not ready).
- stallreq_id  in  1  ID requests hold (load-use hazard).
- stallreq_ex  in  1  EX requests hold (multi-cycle mult/div).
- stallreq_mem  in  1  MEM requests hold (data memory not ready).
- excp_valid  in  1  MEM stage reports an exception this cycle.
- excp_handler  in  32  handler address accompanying excp_valid.
- stall  out  6  bit0 PC, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 WB; 1 = hold.
- flush  out  1  clear all inter-stage registers to NOP.
- new_pc  out  32  redirect target; valid while flush=1.
- stall_cnt  out  CNT_W  total stalled cycles, saturating.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- While rst=0, all outputs are 0, the FSM is in RUN, and the internal run-length counter is 0. Reset is asynchronous, so a reset in the middle of a flush or stall aborts it immediately.
- FSM states: RUN, STALL, FLUSH.
- The stall vector is combinational from the requests in RUN/STALL. The latest-stage request wins:
  - mem -> 011111
  - ex -> 001111
  - id -> 000111
  - if -> 000011
  - none -> 000000
- In FLUSH, stall = 000000 and all stallreq_* are ignored.
- RUN -> STALL: any stallreq_* = 1 and excp_valid = 0.
- STALL -> RUN: all requests are 0.
- RUN/STALL -> FLUSH: excp_valid = 1. This has priority over stall requests in the same cycle; the stall vector that cycle is still the combinational value.
- On acceptance of an exception, next cycle: flush=1, new_pc = registered excp_handler.
- flush stays 1 for exactly FLUSH_CYCLES cycles, then the FSM returns to RUN. new_pc holds its value until the next exception is accepted.
- excp_valid asserted while in FLUSH is ignored (first exception wins).
- Exception-to-flush latency is exactly 1 cycle.
- stall_cnt increments by 1 on every cycle where stall != 0. It saturates at all-ones and never wraps.
- Run-length counter:
  - Counts consecutive cycles with stall != 0.
  - Clears on any cycle with stall = 0, and on entry to FLUSH.
  - When it reaches STALL_TIMEOUT, stall_timeout sets and stays 1 until reset.
- stall_timeout does not alter stall behaviour (diagnostic only).
- Only stall, flush, new_pc, stall_cnt and stall_timeout are outputs; there are no other side effects.

Test Plan:
- Reset: rst=0 with random inputs -> stall=0, flush=0, new_pc=0, stall_cnt=0, stall_timeout=0. Release rst -> FSM in RUN.
- Priority: stallreq_if=1 and stallreq_ex=1 together -> stall=001111. Drop stallreq_ex -> stall=000011. Drop all -> stall=000000; stall_cnt increments by exactly the number of stalled cycles.
- Exception vs. stall: stallreq_mem=1 and excp_valid=1 with excp_handler=0x00000040 in the same cycle -> that cycle stall=011111. Next cycle flush=1, new_pc=0x00000040, stall=000000 for FLUSH_CYCLES cycles, then RUN.
- Second exception: with FLUSH_CYCLES=3, pulse excp_valid with handler=0x100 during FLUSH -> new_pc stays at the first handler and flush lasts exactly 3 cycles.
- Watchdog: with STALL_TIMEOUT=8, hold stallreq_id=1 for 7 cycles, release, then hold for 8 cycles -> stall_timeout=0 after the first run and 1 after the 8th cycle of the second run; it remains 1 after the request drops.
- Saturation and reset: with CNT_W=4, stall for 20 cycles -> stall_cnt=15. Assert rst=0 mid-flush -> flush=0 and stall_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Stage-to-controller bundle for pipe_ctrl: stall requests and exception report in,
// stall vector, flush/redirect and diagnostics out.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             excp_valid;
    logic [31:0]      excp_handler;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_timeout;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_handler,
        input  stall, flush, new_pc, stall_cnt, stall_timeout
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_handler,
        output stall, flush, new_pc, stall_cnt, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall vector, multi-cycle exception flush with
// redirect PC, saturating stall-cycle counter and sticky stall watchdog.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int RW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [FW-1:0]    FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [RW-1:0]    TIMEOUT_V  = RW'(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]    run_len_q, run_len_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic             timeout_q, timeout_d;
    logic [5:0]       stall_vec;
    logic             any_req;
    logic             accept;

    assign any_req = bus.stallreq_if | bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;
    assign accept  = (state_q != FLUSH) && bus.excp_valid;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.excp_valid)   state_d = FLUSH;
                else if (any_req)     state_d = STALL;
            end
            STALL: begin
                if (bus.excp_valid)   state_d = FLUSH;
                else if (!any_req)    state_d = RUN;
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Output logic; stall is masked during reset so every output reads 0.
    always_comb begin
        stall_vec = 6'b000000;
        if (state_q != FLUSH) begin
            if (bus.stallreq_mem)     stall_vec = 6'b011111;
            else if (bus.stallreq_ex) stall_vec = 6'b001111;
            else if (bus.stallreq_id) stall_vec = 6'b000111;
            else if (bus.stallreq_if) stall_vec = 6'b000011;
        end
        bus.stall         = rst ? stall_vec : 6'b000000;
        bus.flush         = (state_q == FLUSH);
        bus.new_pc        = new_pc_q;
        bus.stall_cnt     = stall_cnt_q;
        bus.stall_timeout = timeout_q;
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        new_pc_d    = new_pc_q;
        stall_cnt_d = stall_cnt_q;
        run_len_d   = run_len_q;
        timeout_d   = timeout_q;

        if (accept) begin
            flush_cnt_d = '0;
            new_pc_d    = bus.excp_handler;
        end else if (state_q == FLUSH) begin
            flush_cnt_d = flush_cnt_q + FW'(1);
        end

        if ((stall_vec != 6'b000000) && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        // Run length saturates at the threshold so it can never wrap back below it.
        if (accept || (stall_vec == 6'b000000))
            run_len_d = '0;
        else if (run_len_q != TIMEOUT_V)
            run_len_d = run_len_q + RW'(1);

        if ((stall_vec != 6'b000000) && (run_len_q == TIMEOUT_V - RW'(1)))
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt_q <= '0;
            new_pc_q    <= '0;
            stall_cnt_q <= '0;
            run_len_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
            run_len_q   <= run_len_d;
            timeout_q   <= timeout_d;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES=3, STALL_TIMEOUT=8, CNT_W=4.
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_ctrl_if #(.CNT_W(4)) bus ();

    pipe_ctrl #(
        .FLUSH_CYCLES (3),
        .STALL_TIMEOUT(8),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if} = r;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_req(4'($urandom_range(15)));
        bus.excp_valid   = 1'($urandom_range(1));
        bus.excp_handler = $urandom;
        #13;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL reset_stall got=%b exp=000000", bus.stall); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
        checks++; if (bus.new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got=%h exp=0", bus.new_pc); end
        checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
        checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus.stall_timeout); end
        set_req(4'b0000);
        bus.excp_valid   = 1'b0;
        bus.excp_handler = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (bus.flush !== 1'b0 || bus.stall !== 6'b0) begin errors++; $display("FAIL reset_release flush=%b stall=%b exp 0/000000", bus.flush, bus.stall); end
        $display("test_reset done");
    endtask

    task automatic test_priority();
        logic [3:0] reqs [5];
        logic [5:0] exps [5];
        reqs = '{4'b0101, 4'b0001, 4'b0011, 4'b1001, 4'b0000};
        exps = '{6'b001111, 6'b000011, 6'b000111, 6'b011111, 6'b000000};
        for (int i = 0; i < 5; i++) begin
            set_req(reqs[i]);
            #1;
            checks++; if (bus.stall !== exps[i]) begin errors++; $display("FAIL priority_%0d req=%b got=%b exp=%b", i, reqs[i], bus.stall, exps[i]); end
            tick();
            $display("priority req=%b stall=%b cnt=%0d", reqs[i], bus.stall, bus.stall_cnt);
        end
        checks++; if (bus.stall_cnt !== 4'd4) begin errors++; $display("FAIL priority_cnt got=%0d exp=4", bus.stall_cnt); end
    endtask

    task automatic test_exception();
        set_req(4'b1000);
        bus.excp_valid   = 1'b1;
        bus.excp_handler = 32'h0000_0040;
        #1;
        checks++; if (bus.stall !== 6'b011111) begin errors++; $display("FAIL excp_same_cycle_stall got=%b exp=011111", bus.stall); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL excp_same_cycle_flush got=%b exp=0", bus.flush); end
        tick();
        bus.excp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) set_req(4'b0000);
            #1;
            checks++; if (bus.flush !== 1'b1 || bus.stall !== 6'b0) begin errors++; $display("FAIL excp_flush_%0d flush=%b stall=%b exp 1/000000", i, bus.flush, bus.stall); end
            checks++; if (bus.new_pc !== 32'h40) begin errors++; $display("FAIL excp_new_pc_%0d got=%h exp=00000040", i, bus.new_pc); end
            tick();
        end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL excp_end_flush got=%b exp=0", bus.flush); end
        checks++; if (bus.stall_cnt !== 4'd5) begin errors++; $display("FAIL excp_cnt got=%0d exp=5", bus.stall_cnt); end
        checks++; if (bus.new_pc !== 32'h40) begin errors++; $display("FAIL excp_pc_hold got=%h exp=00000040", bus.new_pc); end
        $display("exception handler=%h new_pc=%h cnt=%0d", 32'h40, bus.new_pc, bus.stall_cnt);
    endtask

    task automatic test_second_exception();
        bus.excp_valid   = 1'b1;
        bus.excp_handler = 32'h0000_0200;
        tick();
        bus.excp_handler = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL excp2_flush_%0d got=%b exp=1", i, bus.flush); end
            checks++; if (bus.new_pc !== 32'h200) begin errors++; $display("FAIL excp2_pc_%0d got=%h exp=00000200", i, bus.new_pc); end
            tick();
            bus.excp_valid = 1'b0;
        end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL excp2_len got=%b exp=0", bus.flush); end
        $display("second_exception new_pc=%h", bus.new_pc);
    endtask

    task automatic test_watchdog();
        set_req(4'b0010);
        repeat (7) tick();
        checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_first_run got=%b exp=0", bus.stall_timeout); end
        checks++; if (bus.stall_cnt !== 4'd12) begin errors++; $display("FAIL wd_cnt got=%0d exp=12", bus.stall_cnt); end
        set_req(4'b0000);
        tick();
        set_req(4'b0010);
        repeat (7) tick();
        checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_7th got=%b exp=0", bus.stall_timeout); end
        tick();
        checks++; if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_8th got=%b exp=1", bus.stall_timeout); end
        checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL wd_sat got=%0d exp=15", bus.stall_cnt); end
        set_req(4'b0000);
        tick();
        checks++; if (bus.stall_timeout !== 1'b1 || bus.stall !== 6'b0) begin errors++; $display("FAIL wd_sticky to=%b stall=%b exp 1/000000", bus.stall_timeout, bus.stall); end
        $display("watchdog timeout=%b cnt=%0d", bus.stall_timeout, bus.stall_cnt);
    endtask

    task automatic test_saturation_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        set_req(4'b0100);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (bus.stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got=%0d exp=14", bus.stall_cnt); end
            end
        end
        checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_20 got=%0d exp=15", bus.stall_cnt); end
        checks++; if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL sat_timeout got=%b exp=1", bus.stall_timeout); end
        bus.excp_valid   = 1'b1;
        bus.excp_handler = 32'h0000_0080;
        tick();
        bus.excp_valid = 1'b0;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL midflush_pre got=%b exp=1", bus.flush); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL midflush_flush got=%b exp=0", bus.flush); end
        checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL midflush_cnt got=%0d exp=0", bus.stall_cnt); end
        checks++; if (bus.new_pc !== 32'h0 || bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL midflush_regs pc=%h to=%b exp 0/0", bus.new_pc, bus.stall_timeout); end
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL midflush_stall got=%b exp=000000", bus.stall); end
        set_req(4'b0000);
        @(negedge clk);
        rst = 1'b1;
        $display("saturation_reset cnt=%0d flush=%b", bus.stall_cnt, bus.flush);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_priority();
        test_exception();
        test_second_exception();
        test_watchdog();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
